// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator: sequential stepping, trap/branch redirect arbitration,
// stall and imem handshake handling, and a post-reset boot hold.
module pc_gen_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned     INSTR_BYTES  = 4,
    parameter int unsigned     BOOT_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic            br_valid_i,
    input  logic [XLEN-1:0] br_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            fetch_valid_o,
    output logic            redirect_o,
    output logic            misaligned_o
);

    localparam int unsigned    CntW     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] BootLast = CntW'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              redirect_q, redirect_d;
    logic [XLEN-1:0]   pend_q, pend_d;
    logic              pend_trap_q, pend_trap_d;

    logic [XLEN-1:0]   trap_tgt, br_tgt, sel_tgt, merge_tgt;
    logic              merge_trap, adv;

    // Redirect targets are halfword addresses: bit 0 never reaches the PC.
    assign trap_tgt = {trap_target_i[XLEN-1:1], 1'b0};
    assign br_tgt   = {br_target_i[XLEN-1:1], 1'b0};
    assign sel_tgt  = trap_valid_i ? trap_tgt : br_tgt;
    assign adv      = !stall_i && fetch_ready_i;

    assign pc_o         = pc_q;
    assign pc_plus_o    = pc_q + XLEN'(INSTR_BYTES);
    assign redirect_o   = redirect_q;
    assign misaligned_o = (INSTR_BYTES == 4) && pc_q[1];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_d          = pc_q;
        redirect_d    = 1'b0;
        pend_d        = pend_q;
        pend_trap_d   = pend_trap_q;
        fetch_valid_o = 1'b0;
        merge_tgt     = pend_q;
        merge_trap    = pend_trap_q;

        unique case (state_q)
            StBoot: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BootLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                fetch_valid_o = !stall_i;
                if (trap_valid_i || br_valid_i) begin
                    if (adv) begin
                        pc_d       = sel_tgt;
                        redirect_d = 1'b1;
                    end else begin
                        pend_d      = sel_tgt;
                        pend_trap_d = trap_valid_i;
                        state_d     = StHold;
                    end
                end else if (adv) begin
                    pc_d = pc_plus_o;
                end
            end
            StHold: begin
                // A pending trap can only be displaced by a newer trap.
                if (trap_valid_i) begin
                    merge_tgt  = trap_tgt;
                    merge_trap = 1'b1;
                end else if (br_valid_i && !pend_trap_q) begin
                    merge_tgt  = br_tgt;
                    merge_trap = 1'b0;
                end
                pend_d      = merge_tgt;
                pend_trap_d = merge_trap;
                if (!stall_i) begin
                    pc_d        = merge_tgt;
                    redirect_d  = 1'b1;
                    state_d     = StRun;
                    pend_d      = '0;
                    pend_trap_d = 1'b0;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StBoot;
            cnt_q       <= '0;
            pc_q        <= RESET_VECTOR;
            redirect_q  <= 1'b0;
            pend_q      <= '0;
            pend_trap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            redirect_q  <= redirect_d;
            pend_q      <= pend_d;
            pend_trap_q <= pend_trap_d;
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit with default parameters (XLEN=32, reset vector 0,
// 4-byte step, 2 boot cycles).
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        fetch_ready_i = 1'b1;
    logic        trap_valid_i = 1'b0;
    logic [31:0] trap_target_i = '0;
    logic        br_valid_i = 1'b0;
    logic [31:0] br_target_i = '0;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_o;
    logic        fetch_valid_o;
    logic        redirect_o;
    logic        misaligned_o;

    int checks = 0;
    int failures = 0;

    pc_gen_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .fetch_ready_i (fetch_ready_i),
        .trap_valid_i  (trap_valid_i),
        .trap_target_i (trap_target_i),
        .br_valid_i    (br_valid_i),
        .br_target_i   (br_target_i),
        .pc_o          (pc_o),
        .pc_plus_o     (pc_plus_o),
        .fetch_valid_o (fetch_valid_o),
        .redirect_o    (redirect_o),
        .misaligned_o  (misaligned_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want %h", pc_o, 32'h0); end
        checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL rst_fv: got %b want 0", fetch_valid_o); end
        checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL rst_redir: got %b want 0", redirect_o); end
        rst = 1'b0;
        br_valid_i = 1'b1; br_target_i = 32'h500;
        #1;
        checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL boot0_fv: got %b want 0", fetch_valid_o); end
        tick();
        br_valid_i = 1'b0;
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL boot1_pc: got %h want %h", pc_o, 32'h0); end
        checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL boot1_fv: got %b want 0", fetch_valid_o); end
        tick();
        checks++; if (fetch_valid_o !== 1'b1) begin failures++; $display("FAIL boot2_fv: got %b want 1", fetch_valid_o); end
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL boot2_pc: got %h want %h", pc_o, 32'h0); end
        checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL boot2_redir: got %b want 0", redirect_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc_o !== exp_pc[i]) begin failures++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_o, exp_pc[i]); end
            checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL seq_redir[%0d]: got %b want 0", i, redirect_o); end
        end
        checks++; if (pc_plus_o !== 32'h10) begin failures++; $display("FAIL seq_pc_plus: got %h want %h", pc_plus_o, 32'h10); end
        checks++; if (misaligned_o !== 1'b0) begin failures++; $display("FAIL seq_mis: got %b want 0", misaligned_o); end
        fetch_ready_i = 1'b0;
        tick();
        checks++; if (pc_o !== 32'hC) begin failures++; $display("FAIL notready_pc: got %h want %h", pc_o, 32'hC); end
        checks++; if (fetch_valid_o !== 1'b1) begin failures++; $display("FAIL notready_fv: got %b want 1", fetch_valid_o); end
        fetch_ready_i = 1'b1;
    endtask

    task automatic test_trap_priority();
        trap_valid_i = 1'b1; trap_target_i = 32'h100;
        br_valid_i = 1'b1; br_target_i = 32'h200;
        tick();
        trap_valid_i = 1'b0; br_valid_i = 1'b0;
        checks++; if (pc_o !== 32'h100) begin failures++; $display("FAIL prio_pc: got %h want %h", pc_o, 32'h100); end
        checks++; if (redirect_o !== 1'b1) begin failures++; $display("FAIL prio_redir: got %b want 1", redirect_o); end
        tick();
        checks++; if (pc_o !== 32'h104) begin failures++; $display("FAIL prio_next_pc: got %h want %h", pc_o, 32'h104); end
        checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL prio_redir_drop: got %b want 0", redirect_o); end
    endtask

    task automatic test_hold_merge();
        stall_i = 1'b1;
        br_valid_i = 1'b1; br_target_i = 32'h40;
        #1;
        checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL stall_fv: got %b want 0", fetch_valid_o); end
        tick();
        br_valid_i = 1'b0;
        trap_valid_i = 1'b1; trap_target_i = 32'h80;
        tick();
        trap_valid_i = 1'b0;
        checks++; if (pc_o !== 32'h104) begin failures++; $display("FAIL hold_pc: got %h want %h", pc_o, 32'h104); end
        checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL hold_fv: got %b want 0", fetch_valid_o); end
        checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL hold_redir: got %b want 0", redirect_o); end
        br_valid_i = 1'b1; br_target_i = 32'h60;
        tick();
        br_valid_i = 1'b0;
        stall_i = 1'b0;
        tick();
        checks++; if (pc_o !== 32'h80) begin failures++; $display("FAIL release_pc: got %h want %h", pc_o, 32'h80); end
        checks++; if (redirect_o !== 1'b1) begin failures++; $display("FAIL release_redir: got %b want 1", redirect_o); end
        tick();
        checks++; if (pc_o !== 32'h84) begin failures++; $display("FAIL release_next: got %h want %h", pc_o, 32'h84); end
        checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL release_redir_drop: got %b want 0", redirect_o); end
    endtask

    task automatic test_back_to_back();
        // Two adjacent accepted branches, then a pending branch replaced by one arriving on release.
        br_valid_i = 1'b1; br_target_i = 32'h200;
        tick();
        br_target_i = 32'h300;
        tick();
        br_valid_i = 1'b0;
        checks++; if (pc_o !== 32'h300) begin failures++; $display("FAIL b2b_pc: got %h want %h", pc_o, 32'h300); end
        checks++; if (redirect_o !== 1'b1) begin failures++; $display("FAIL b2b_redir: got %b want 1", redirect_o); end
        stall_i = 1'b1;
        br_valid_i = 1'b1; br_target_i = 32'h40;
        tick();
        stall_i = 1'b0;
        br_target_i = 32'h48;
        tick();
        br_valid_i = 1'b0;
        checks++; if (pc_o !== 32'h48) begin failures++; $display("FAIL merge_pc: got %h want %h", pc_o, 32'h48); end
        checks++; if (redirect_o !== 1'b1) begin failures++; $display("FAIL merge_redir: got %b want 1", redirect_o); end
    endtask

    task automatic test_misaligned_wrap();
        br_valid_i = 1'b1; br_target_i = 32'h1F2;
        tick();
        br_valid_i = 1'b0;
        checks++; if (pc_o !== 32'h1F2) begin failures++; $display("FAIL mis_pc: got %h want %h", pc_o, 32'h1F2); end
        checks++; if (misaligned_o !== 1'b1) begin failures++; $display("FAIL mis_flag: got %b want 1", misaligned_o); end
        tick();
        checks++; if (pc_o !== 32'h1F6) begin failures++; $display("FAIL mis_step: got %h want %h", pc_o, 32'h1F6); end
        trap_valid_i = 1'b1; trap_target_i = 32'hFFFF_FFFC;
        tick();
        trap_valid_i = 1'b0;
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top: got %h want %h", pc_o, 32'hFFFF_FFFC); end
        checks++; if (pc_plus_o !== 32'h0) begin failures++; $display("FAIL wrap_plus: got %h want %h", pc_plus_o, 32'h0); end
        checks++; if (misaligned_o !== 1'b0) begin failures++; $display("FAIL wrap_mis: got %b want 0", misaligned_o); end
        tick();
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h want %h", pc_o, 32'h0); end
        checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL wrap_redir: got %b want 0", redirect_o); end
        br_valid_i = 1'b1; br_target_i = 32'h123;
        tick();
        br_valid_i = 1'b0;
        checks++; if (pc_o !== 32'h122) begin failures++; $display("FAIL bit0_pc: got %h want %h", pc_o, 32'h122); end
    endtask

    task automatic test_reset_mid_hold();
        stall_i = 1'b1;
        br_valid_i = 1'b1; br_target_i = 32'h300;
        tick();
        br_valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL async_pc: got %h want %h", pc_o, 32'h0); end
        checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL async_fv: got %b want 0", fetch_valid_o); end
        checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL async_redir: got %b want 0", redirect_o); end
        tick();
        tick();
        rst = 1'b0;
        stall_i = 1'b0;
        tick();
        checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL reboot_fv: got %b want 0", fetch_valid_o); end
        tick();
        checks++; if (fetch_valid_o !== 1'b1) begin failures++; $display("FAIL reboot_run_fv: got %b want 1", fetch_valid_o); end
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL reboot_pc: got %h want %h", pc_o, 32'h0); end
        tick();
        checks++; if (pc_o !== 32'h4) begin failures++; $display("FAIL pending_lost: got %h want %h", pc_o, 32'h4); end
        checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL pending_redir: got %b want 0", redirect_o); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_trap_priority();
        test_hold_merge();
        test_back_to_back();
        test_misaligned_wrap();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
